// File: rtl/vx_ahb_mem_arbiter.sv
// Round-robin arbiter funnelling NUM_REQS line requesters onto one AHB memory adapter.
// Only one transaction is outstanding downstream at a time, and a watchdog guards each response wait.
module vx_ahb_mem_arbiter #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 56,
  parameter int TIMEOUT    = 1024,
  localparam int OW        = $clog2(NUM_REQS)
) (
  input  logic                             clk,
  input  logic                             nRST,
  input  logic [NUM_REQS-1:0]              up_req_valid,
  input  logic [NUM_REQS-1:0]              up_req_rw,
  input  logic [NUM_REQS*DATA_WIDTH/8-1:0] up_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   up_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   up_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]    up_req_tag,
  output logic [NUM_REQS-1:0]              up_req_ready,
  output logic [NUM_REQS-1:0]              up_rsp_valid,
  input  logic [NUM_REQS-1:0]              up_rsp_ready,
  output logic [DATA_WIDTH-1:0]            up_rsp_data,
  output logic [TAG_WIDTH-1:0]             up_rsp_tag,
  output logic                             dn_req_valid,
  output logic                             dn_req_rw,
  output logic [DATA_WIDTH/8-1:0]          dn_req_byteen,
  output logic [ADDR_WIDTH-1:0]            dn_req_addr,
  output logic [DATA_WIDTH-1:0]            dn_req_data,
  output logic [TAG_WIDTH-1:0]             dn_req_tag,
  input  logic                             dn_req_ready,
  input  logic                             dn_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            dn_rsp_data,
  input  logic [TAG_WIDTH-1:0]             dn_rsp_tag,
  output logic                             dn_rsp_ready,
  output logic                             busy,
  output logic [OW-1:0]                    owner,
  output logic                             err_timeout,
  input  logic                             err_clear
);

  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [OW-1:0]           last_grant_q, last_grant_d;
  logic [OW-1:0]           owner_q, owner_d;
  logic                    rw_q, rw_d;
  logic [BW-1:0]           byteen_q, byteen_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [TAG_WIDTH-1:0]    rsp_tag_q, rsp_tag_d;
  logic [15:0]             wd_q, wd_d;
  logic                    err_q, err_d;
  logic                    timeout;

  // Unflatten the per-requester buses so the winner can index them directly.
  logic [BW-1:0]         byteen_a [NUM_REQS];
  logic [ADDR_WIDTH-1:0] addr_a   [NUM_REQS];
  logic [DATA_WIDTH-1:0] data_a   [NUM_REQS];
  logic [TAG_WIDTH-1:0]  tag_a    [NUM_REQS];

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_slice
    assign byteen_a[g] = up_req_byteen[g*BW +: BW];
    assign addr_a[g]   = up_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[g]   = up_req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign tag_a[g]    = up_req_tag[g*TAG_WIDTH +: TAG_WIDTH];
  end

  logic          found;
  logic [OW-1:0] winner;
  logic [OW-1:0] idx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = OW'((int'(last_grant_q) + 1 + i) % NUM_REQS);
      if (!found && up_req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    rw_d         = rw_q;
    byteen_d     = byteen_q;
    addr_d       = addr_q;
    data_d       = data_q;
    tag_d        = tag_q;
    rsp_data_d   = rsp_data_q;
    rsp_tag_d    = rsp_tag_q;
    wd_d         = wd_q;
    err_d        = err_q;
    timeout      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d      = winner;
          last_grant_d = winner;
          rw_d         = up_req_rw[winner];
          byteen_d     = byteen_a[winner];
          addr_d       = addr_a[winner];
          data_d       = data_a[winner];
          tag_d        = tag_a[winner];
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dn_req_ready) begin
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dn_rsp_valid) begin
          rsp_data_d = dn_rsp_data;
          rsp_tag_d  = dn_rsp_tag;
          state_d    = S_RESP;
        end else if (wd_q == 16'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_RESP: begin
        if (up_rsp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A timeout in the same cycle as a clear must still leave the flag set.
    if (err_clear) err_d = 1'b0;
    if (timeout)   err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the wide line registers are reset only because outputs must read 0 while nRST is low.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      last_grant_q <= OW'(NUM_REQS - 1);
      owner_q      <= '0;
      rw_q         <= 1'b0;
      byteen_q     <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      tag_q        <= '0;
      rsp_data_q   <= '0;
      rsp_tag_q    <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      rw_q         <= rw_d;
      byteen_q     <= byteen_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
      rsp_data_q   <= rsp_data_d;
      rsp_tag_q    <= rsp_tag_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
    end
  end

  assign up_req_ready  = (state_q == S_IDLE && found) ? (NUM_REQS'(1) << winner) : '0;
  assign up_rsp_valid  = (state_q == S_RESP) ? (NUM_REQS'(1) << owner_q) : '0;
  assign up_rsp_data   = rsp_data_q;
  assign up_rsp_tag    = rsp_tag_q;
  assign dn_req_valid  = (state_q == S_ISSUE);
  assign dn_req_rw     = rw_q;
  assign dn_req_byteen = byteen_q;
  assign dn_req_addr   = addr_q;
  assign dn_req_data   = data_q;
  assign dn_req_tag    = tag_q;
  // Responses seen outside WAIT are stale leftovers from a timeout or reset; accept and drop them.
  assign dn_rsp_ready  = (state_q != S_RESP);
  assign busy          = (state_q != S_IDLE);
  assign owner         = owner_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_vx_ahb_mem_arbiter.sv
// Self-checking bench for vx_ahb_mem_arbiter: a grant monitor fills a scoreboard that the
// response monitor drains, and a behavioural memory answers downstream requests.
module tb_vx_ahb_mem_arbiter;

  localparam int NR = 4;
  localparam int DW = 512;
  localparam int AW = 26;
  localparam int TW = 56;
  localparam int TO = 16;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              nRST;
  logic [NR-1:0]     up_req_valid, up_req_rw, up_req_ready;
  logic [NR*BW-1:0]  up_req_byteen;
  logic [NR*AW-1:0]  up_req_addr;
  logic [NR*DW-1:0]  up_req_data;
  logic [NR*TW-1:0]  up_req_tag;
  logic [NR-1:0]     up_rsp_valid, up_rsp_ready;
  logic [DW-1:0]     up_rsp_data;
  logic [TW-1:0]     up_rsp_tag;
  logic              dn_req_valid, dn_req_rw, dn_req_ready;
  logic [BW-1:0]     dn_req_byteen;
  logic [AW-1:0]     dn_req_addr;
  logic [DW-1:0]     dn_req_data;
  logic [TW-1:0]     dn_req_tag;
  logic              dn_rsp_valid, dn_rsp_ready;
  logic [DW-1:0]     dn_rsp_data;
  logic [TW-1:0]     dn_rsp_tag;
  logic              busy, err_timeout, err_clear;
  logic [1:0]        owner;

  vx_ahb_mem_arbiter #(
    .NUM_REQS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .nRST(nRST),
    .up_req_valid(up_req_valid), .up_req_rw(up_req_rw), .up_req_byteen(up_req_byteen),
    .up_req_addr(up_req_addr), .up_req_data(up_req_data), .up_req_tag(up_req_tag),
    .up_req_ready(up_req_ready),
    .up_rsp_valid(up_rsp_valid), .up_rsp_ready(up_rsp_ready),
    .up_rsp_data(up_rsp_data), .up_rsp_tag(up_rsp_tag),
    .dn_req_valid(dn_req_valid), .dn_req_rw(dn_req_rw), .dn_req_byteen(dn_req_byteen),
    .dn_req_addr(dn_req_addr), .dn_req_data(dn_req_data), .dn_req_tag(dn_req_tag),
    .dn_req_ready(dn_req_ready),
    .dn_rsp_valid(dn_rsp_valid), .dn_rsp_data(dn_rsp_data), .dn_rsp_tag(dn_rsp_tag),
    .dn_rsp_ready(dn_rsp_ready),
    .busy(busy), .owner(owner), .err_timeout(err_timeout), .err_clear(err_clear)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int            who;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rsp_lat = 3;
  bit   drop_rsp = 1'b0;
  bit   no_rsp_expected = 1'b0;
  int   late_req = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Memory model: response data is a fixed function of the request address and tag.
  function automatic logic [DW-1:0] model(input logic [AW-1:0] a, input logic [TW-1:0] t);
    logic [31:0] w;
    w = 32'(a) ^ t[31:0] ^ {8'h00, t[55:32]} ^ 32'h5A5A_C3C3;
    return {(DW/32){w}};
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a,
                         input logic [TW-1:0] t, input logic [DW-1:0] d, input logic [BW-1:0] be);
    up_req_rw[i]              = rw;
    up_req_addr[i*AW +: AW]   = a;
    up_req_tag[i*TW +: TW]    = t;
    up_req_data[i*DW +: DW]   = d;
    up_req_byteen[i*BW +: BW] = be;
    up_req_valid[i]           = 1'b1;
  endtask

  task automatic wait_grant(input int budget, output int who);
    who = -1;
    #1;
    for (int c = 0; c < budget; c++) begin
      if (up_req_ready != '0) begin
        for (int i = 0; i < NR; i++) if (up_req_ready[i]) who = i;
        return;
      end
      tick();
    end
    check("grant_wait_expired", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      tick();
      if (!busy && sb.size() == 0) return;
    end
    check("idle_wait_expired", 0, 1);
  endtask

  // Downstream responder: answers each accepted request after rsp_lat cycles.
  initial begin : responder
    logic [AW-1:0] p_addr;
    logic [TW-1:0] p_tag;
    int            cnt;
    bit            pend, hs, done;
    int            late_done;
    pend = 1'b0; cnt = 0; late_done = 0; p_addr = '0; p_tag = '0;
    dn_rsp_valid = 1'b0; dn_rsp_data = '0; dn_rsp_tag = '0;
    forever begin
      @(negedge clk); #3;
      hs   = dn_req_valid && dn_req_ready;
      done = dn_rsp_valid && dn_rsp_ready;
      if (hs) begin
        p_addr = dn_req_addr;
        p_tag  = dn_req_tag;
      end
      #1;
      if (done) dn_rsp_valid = 1'b0;
      if (hs) begin
        cnt  = rsp_lat;
        pend = !drop_rsp;
      end else if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          dn_rsp_valid = 1'b1;
          dn_rsp_data  = model(p_addr, p_tag);
          dn_rsp_tag   = p_tag;
          pend         = 1'b0;
        end
      end else if (late_req != late_done) begin
        late_done    = late_req;
        dn_rsp_valid = 1'b1;
        dn_rsp_data  = '1;
        dn_rsp_tag   = 56'hDEAD;
      end
    end
  end

  // Grant and response monitor: pushes expectations on grant, pops them on response handshake.
  initial begin : monitor
    exp_t e;
    int   idx;
    forever begin
      @(negedge clk); #3;
      if (up_req_ready != '0) begin
        check("ready_onehot", $countones(up_req_ready), 1);
        check("ready_without_valid", up_req_ready & ~up_req_valid, 0);
        for (int i = 0; i < NR; i++) begin
          if (nRST && up_req_ready[i] && up_req_valid[i]) begin
            grants.push_back(i);
            if (!no_rsp_expected) begin
              e.who  = i;
              e.tag  = up_req_tag[i*TW +: TW];
              e.data = model(up_req_addr[i*AW +: AW], up_req_tag[i*TW +: TW]);
              sb.push_back(e);
            end
          end
        end
      end
      if (up_rsp_valid != '0) begin
        idx = 0;
        for (int i = 0; i < NR; i++) if (up_rsp_valid[i]) idx = i;
        if (up_rsp_ready[idx]) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            check("rsp_valid_mask", up_rsp_valid, NR'(1) << e.who);
            check("rsp_tag", up_rsp_tag, e.tag);
            check("rsp_data", up_rsp_data, e.data);
          end
        end
      end
    end
  end

  initial begin : main
    int            who, n;
    bit            flag_a, flag_b, flag_c;
    logic [DW-1:0] d;
    nRST = 1'b1;
    up_req_valid = '0; up_req_rw = '0; up_req_byteen = '0; up_req_addr = '0;
    up_req_data = '0; up_req_tag = '0; up_rsp_ready = '1; dn_req_ready = 1'b1;
    err_clear = 1'b0;
    #2 nRST = 1'b0;
    tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_err", err_timeout, 0);
    check("rst_dn_req_valid", dn_req_valid, 0);
    check("rst_up_rsp_valid", up_rsp_valid, 0);
    check("rst_dn_rsp_ready", dn_rsp_ready, 1);
    check("rst_dn_req_addr", dn_req_addr, 0);
    check("rst_up_req_ready_idle", up_req_ready, 0);
    up_req_valid[2] = 1'b1;
    #1;
    check("rst_up_req_ready_comb", up_req_ready, 4'b0100);
    up_req_valid = '0;
    tick();
    nRST = 1'b1;
    tick();

    // All four requesters contending, 3-cycle memory
    rsp_lat = 3;
    grants.delete();
    for (int i = 0; i < NR; i++)
      set_req(i, 1'b0, AW'(32'h100 + i*4), TW'(56'hA0 + i), rand_line(), '1);
    for (int c = 0; c < 300 && grants.size() < 6; c++) tick();
    up_req_valid = '0;
    wait_idle(200);
    if (grants.size() >= 6) begin
      for (int k = 0; k < 6; k++) check($sformatf("rr_order_%0d", k), grants[k], k % NR);
    end else begin
      check("rr_grant_count", grants.size(), 6);
    end

    // Single write from requester 2 passes through unchanged
    rsp_lat = 2;
    d = rand_line();
    set_req(2, 1'b1, 26'h40, 56'h5A, d, '1);
    wait_grant(20, who);
    check("wr_grant", who, 2);
    tick();
    up_req_valid[2] = 1'b0;
    check("wr_dn_valid", dn_req_valid, 1);
    check("wr_dn_rw", dn_req_rw, 1);
    check("wr_dn_addr", dn_req_addr, 26'h40);
    check("wr_dn_tag", dn_req_tag, 56'h5A);
    check("wr_dn_data", dn_req_data, d);
    check("wr_dn_byteen", dn_req_byteen, 64'hFFFF_FFFF_FFFF_FFFF);
    flag_a = 1'b0; flag_b = 1'b0;
    for (int c = 0; c < 50 && busy; c++) begin
      if (dn_rsp_valid) flag_a = 1'b1;
      if (up_rsp_valid != '0 && !flag_a) flag_b = 1'b1;
      tick();
    end
    check("wr_rsp_after_dn_rsp", flag_b, 0);
    wait_idle(50);

    // Downstream stalls for 5 cycles in ISSUE
    dn_req_ready = 1'b0;
    d = rand_line();
    set_req(0, 1'b0, 26'h1234, 56'hC0FFEE, d, 64'h00FF_0F0F_F0F0_FF00);
    set_req(1, 1'b0, 26'h2000, 56'hB1, rand_line(), '1);
    wait_grant(20, who);
    check("stall_grant", who, 0);
    tick();
    up_req_valid[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_dn_valid", dn_req_valid, 1);
      check("stall_dn_addr", dn_req_addr, 26'h1234);
      check("stall_dn_tag", dn_req_tag, 56'hC0FFEE);
      check("stall_dn_data", dn_req_data, d);
      check("stall_dn_byteen", dn_req_byteen, 64'h00FF_0F0F_F0F0_FF00);
      check("stall_no_grant", up_req_ready, 0);
      tick();
    end
    dn_req_ready = 1'b1;
    wait_grant(50, who);
    check("stall_next_grant", who, 1);
    tick();
    up_req_valid[1] = 1'b0;
    wait_idle(50);

    // Watchdog: memory never answers
    drop_rsp = 1'b1;
    no_rsp_expected = 1'b1;
    set_req(3, 1'b0, 26'h300, 56'h77, rand_line(), '1);
    wait_grant(20, who);
    check("to_grant", who, 3);
    tick();
    up_req_valid[3] = 1'b0;
    n = 0; flag_a = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      n++;
      if (up_rsp_valid != '0) flag_a = 1'b1;
      if (err_timeout) break;
    end
    check("to_sample_of_err", n, TO + 1);
    check("to_busy", busy, 0);
    check("to_no_rsp", flag_a, 0);
    late_req++;
    flag_a = 1'b0; flag_b = 1'b0; flag_c = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dn_rsp_valid) flag_a = 1'b1;
      if (busy || up_rsp_valid != '0) flag_b = 1'b1;
      if (!err_timeout) flag_c = 1'b0;
    end
    check("late_rsp_seen", flag_a, 1);
    check("late_rsp_ignored", flag_b, 0);
    check("late_err_sticky", flag_c, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("err_cleared", err_timeout, 0);
    drop_rsp = 1'b0;
    no_rsp_expected = 1'b0;

    // Requester holds off its response for 4 cycles
    rsp_lat = 1;
    up_rsp_ready = 4'b1110;
    set_req(0, 1'b0, 26'h77, 56'h31, rand_line(), '1);
    set_req(1, 1'b0, 26'h88, 56'h32, rand_line(), '1);
    wait_grant(20, who);
    check("hold_grant", who, 0);
    tick();
    up_req_valid[0] = 1'b0;
    for (int c = 0; c < 50 && up_rsp_valid == '0; c++) tick();
    for (int k = 0; k < 4; k++) begin
      check("hold_rsp_valid", up_rsp_valid, 4'b0001);
      check("hold_rsp_data", up_rsp_data, model(26'h77, 56'h31));
      check("hold_rsp_tag", up_rsp_tag, 56'h31);
      check("hold_no_grant", up_req_ready, 0);
      tick();
    end
    up_rsp_ready = '1;
    tick();
    check("hold_next_ready", up_req_ready, 4'b0010);
    wait_grant(5, who);
    check("hold_next_grant", who, 1);
    tick();
    up_req_valid[1] = 1'b0;
    wait_idle(50);

    // Reset while waiting for the memory
    rsp_lat = 5;
    no_rsp_expected = 1'b1;
    set_req(2, 1'b0, 26'h500, 56'h99, rand_line(), '1);
    wait_grant(20, who);
    check("rstw_grant", who, 2);
    tick();
    up_req_valid[2] = 1'b0;
    tick();
    check("rstw_busy_before", busy, 1);
    nRST = 1'b0;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_owner", owner, 0);
    check("rstw_dn_req_valid", dn_req_valid, 0);
    check("rstw_dn_req_addr", dn_req_addr, 0);
    check("rstw_dn_req_tag", dn_req_tag, 0);
    check("rstw_up_rsp_valid", up_rsp_valid, 0);
    check("rstw_up_rsp_data", up_rsp_data, 0);
    check("rstw_err", err_timeout, 0);
    check("rstw_dn_rsp_ready", dn_rsp_ready, 1);
    tick();
    nRST = 1'b1;
    flag_a = 1'b0; flag_b = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (dn_rsp_valid) flag_a = 1'b1;
      if (busy || up_rsp_valid != '0) flag_b = 1'b1;
    end
    check("rstw_stale_seen", flag_a, 1);
    check("rstw_stale_ignored", flag_b, 0);
    no_rsp_expected = 1'b0;
    for (int i = 0; i < NR; i++)
      set_req(i, 1'b0, AW'(32'h600 + i), TW'(56'hE0 + i), rand_line(), '1);
    wait_grant(20, who);
    check("rstw_first_grant", who, 0);
    tick();
    up_req_valid = '0;
    wait_idle(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_ahb_mem_arbiter.md
VX_AHB_MEM_ARBITER -- requirements
Module: vx_ahb_mem_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQS, 4, number of requesters (2..8); DATA_WIDTH, 512, line width; ADDR_WIDTH, 26, line address; TAG_WIDTH, 56, request tag; TIMEOUT, 1024, response watchdog limit in cycles.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 up_req_valid / up_req_rw  in  NUM_REQS each  per-requester request valid / write.
REQ-005 up_req_byteen  in  NUM_REQS*DATA_WIDTH/8  flattened byte enables; slice i belongs to requester i.
REQ-006 up_req_addr / up_req_data / up_req_tag  in  NUM_REQS*ADDR_WIDTH / *DATA_WIDTH / *TAG_WIDTH  flattened, slice i = requester i.
REQ-007 up_req_ready  out  NUM_REQS  per-requester accept.
REQ-008 up_rsp_valid  out  NUM_REQS; up_rsp_ready  in  NUM_REQS; up_rsp_data  out  DATA_WIDTH; up_rsp_tag  out  TAG_WIDTH (data/tag shared, qualified by up_rsp_valid).
REQ-009 dn_req_valid / dn_req_rw  out  1; dn_req_byteen / dn_req_addr / dn_req_data / dn_req_tag  out  DATA_WIDTH/8 / ADDR_WIDTH / DATA_WIDTH / TAG_WIDTH; dn_req_ready  in  1 (to AHB adapter).
REQ-010 dn_rsp_valid  in  1; dn_rsp_data  in  DATA_WIDTH; dn_rsp_tag  in  TAG_WIDTH; dn_rsp_ready  out  1.
REQ-011 busy  out  1  FSM not IDLE; owner  out  $clog2(NUM_REQS)  current grantee; err_timeout  out  1  sticky watchdog flag; err_clear  in  1  clears err_timeout.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding downstream at any time.
REQ-013 IDLE: if any up_req_valid, winner = first valid index searching from (last_grant+1) mod NUM_REQS upward with wrap; up_req_ready[winner]=1 combinationally that cycle only; rw/byteen/addr/data/tag and owner registered; last_grant<=winner; next state ISSUE.
REQ-014 up_req_ready SHALL be 0 for all non-winners and in all states except IDLE.
REQ-015 ISSUE: dn_req_valid=1 with registered fields held stable; on dn_req_valid&dn_req_ready go WAIT; otherwise remain in ISSUE indefinitely.
REQ-016 WAIT: dn_rsp_ready=1; on dn_rsp_valid register dn_rsp_data and dn_rsp_tag, go RESP; applies to reads and writes alike (downstream responds to both).
REQ-017 RESP: up_rsp_valid[owner]=1, others 0, with registered data/tag; on up_rsp_ready[owner] go IDLE; otherwise hold.
REQ-018 Minimum latency: accept cycle N, dn_req_valid at N+1, earliest up_rsp_valid one cycle after dn_rsp_valid handshake; back-to-back grant no earlier than cycle following RESP handshake.
REQ-019 Watchdog: 16-bit counter cleared on entering WAIT, increments each WAIT cycle without dn_rsp_valid; at count TIMEOUT-1 set err_timeout, go IDLE, no response to owner.
REQ-020 dn_rsp_ready SHALL be 1 in IDLE and ISSUE as well; responses arriving there are stale (post-timeout) and discarded without affecting state.
REQ-021 err_timeout set and err_clear in same cycle: set wins.
REQ-022 A requester dropping up_req_valid before grant SHALL never be granted for that request; a single active requester is granted every transaction.
REQ-023 up_rsp_tag SHALL equal the downstream returned tag, which equals the granted requester's tag unchanged.

Reset
REQ-024 On nRST low, immediately: state IDLE, last_grant NUM_REQS-1 (requester 0 wins first), owner 0, all registered fields 0, watchdog 0, err_timeout 0.
REQ-025 During reset all outputs SHALL be 0 except dn_rsp_ready and up_req_ready, which follow IDLE rules (combinational on inputs).
REQ-026 Reset mid-transaction SHALL abandon it with no response issued; any later downstream response is discarded per REQ-020.

Verification
REQ-027 All 4 requesters valid continuously, responder 3-cycle latency -> grant order 0,1,2,3,0,1; each up_rsp_tag matches the issuer's tag.
REQ-028 Requester 2 write, addr 0x0000040, tag 0x5A, byteen all 1s -> dn_req_* equals inputs exactly; up_rsp_valid[2] only after dn_rsp_valid.
REQ-029 dn_req_ready low for 5 cycles in ISSUE -> dn_req_valid and fields stable all 5 cycles, no second grant.
REQ-030 No dn_rsp_valid for TIMEOUT=16 cycles -> err_timeout=1 at 16th WAIT cycle, state IDLE; late dn_rsp_valid dropped; err_clear -> 0.
REQ-031 up_rsp_ready[owner] low 4 cycles in RESP -> up_rsp_valid and data held; requester 1 valid throughout not granted until handshake.
REQ-032 nRST asserted in WAIT -> all outputs 0 same cycle; after release requester 0 granted first.
